ifetch_unit: RTL and testbench



---
 rtl/riscv_pkg.sv | 24 ++
 rtl/ifetch_unit.sv | 159 +++++++++++++++
 tb/tb_ifetch_unit.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: widths, opcodes, fetch state encoding.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_ERR  = 3'd4
    } ifetch_state_e;

endpackage

// File: rtl/ifetch_unit.sv
// Instruction fetch: owns the PC, issues one imem word fetch at a time,
// holds the result for decode and squashes fetches on redirect.
module ifetch_unit
    import riscv_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic            misalign_err
);

    ifetch_state_e state_q, state_d;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            instr_valid_q, instr_valid_d;
    logic            misalign_q, misalign_d;
    logic            drop_q, drop_d;

    logic redir;
    logic mis;

    // Redirects are ignored only while idling straight out of reset.
    assign redir = redirect_valid && (state_q != S_IDLE);
    assign mis   = |redirect_target[1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; redirect has priority over every handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (redir)         state_d = mis ? S_ERR : S_REQ;
                else if (imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (redir) begin
                    if (imem_rvalid) state_d = mis ? S_ERR : S_REQ;
                    else             state_d = S_WAIT;
                end else if (imem_rvalid) begin
                    if (drop_q) state_d = misalign_q ? S_ERR : S_REQ;
                    else        state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redir)
                    state_d = mis ? S_ERR : S_REQ;
                else if (instr_valid_q && instr_ready)
                    state_d = S_REQ;
            end
            S_ERR: begin
                if (redir && !mis) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: request only in S_REQ, suppressed by a same-cycle redirect.
    always_comb begin
        imem_req  = (state_q == S_REQ) && !redir && !rst;
        imem_addr = fetch_pc_q;
    end

    // Datapath register update.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC[XLEN-1:0];
            pend_pc_q     <= '0;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            pend_pc_q     <= pend_pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            misalign_q    <= misalign_d;
            drop_q        <= drop_d;
        end
    end

    // Datapath next-state; an in-flight fetch at redirect time is dropped.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        pend_pc_d     = pend_pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        misalign_d    = misalign_q;
        drop_d        = drop_q;
        if (redir) begin
            fetch_pc_d    = redirect_target;
            instr_valid_d = 1'b0;
            misalign_d    = mis;
            if (state_q == S_WAIT) drop_d = !imem_rvalid;
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (imem_gnt) begin
                        pend_pc_d  = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + XLEN'(4);
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_q) begin
                            drop_d = 1'b0;
                        end else begin
                            instr_d       = imem_rdata[31:0];
                            instr_pc_d    = pend_pc_q;
                            instr_valid_d = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (instr_valid_q && instr_ready)
                        instr_valid_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign instr_valid  = instr_valid_q;
    assign instr        = instr_q;
    assign instr_pc     = instr_pc_q;
    assign misalign_err = misalign_q;
    assign opcode       = instr_q[6:0];
    assign funct3       = instr_q[14:12];
    assign funct7       = instr_q[31:25];

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: directed memory responses,
// redirect/misalign scenarios and a PC wrap-around instance.
module tb_ifetch_unit;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        misalign_err;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_gnt;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic        w_ivalid;
    logic [31:0] w_instr;
    logic [31:0] w_ipc;
    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic        w_mis;
    logic        w_done = 1'b0;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    ifetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .misalign_err(misalign_err)
    );

    ifetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_gnt(w_gnt), .imem_rvalid(w_rvalid),
        .imem_rdata(w_rdata),
        .redirect_valid(1'b0),
        .redirect_target(32'h0),
        .instr_valid(w_ivalid), .instr_ready(1'b1),
        .instr(w_instr), .instr_pc(w_ipc),
        .opcode(w_op), .funct3(w_f3), .funct7(w_f7),
        .misalign_err(w_mis)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h",
                     name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted instruction must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready && !redirect_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_delivery", instr_pc, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("deliver_instr", instr, e.ins);
                chk("deliver_pc", instr_pc, e.pc);
                chk("deliver_f7", {25'd0, funct7}, {25'd0, e.ins[31:25]});
            end
        end
    end

    task automatic wait_req(input logic [31:0] addr);
        int n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        chk("req_seen", {31'd0, imem_req}, 32'd1);
        chk("req_addr", imem_addr, addr);
    endtask

    // Grant after gdly stall cycles, return data rdly cycles after gnt.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                         input int gdly, input int rdly, input bit deliver);
        exp_t e;
        wait_req(addr);
        for (int i = 0; i < gdly; i++) begin
            step();
            chk("stall_req", {31'd0, imem_req}, 32'd1);
            chk("stall_addr", imem_addr, addr);
        end
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        chk("no_dup_req", {31'd0, imem_req}, 32'd0);
        for (int i = 1; i < rdly; i++) step();
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        e.ins = data;
        e.pc  = addr;
        if (deliver) sb.push_back(e);
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        redirect_valid  = 1'b1;
        redirect_target = tgt;
        step();
        redirect_valid  = 1'b0;
    endtask

    // Wrap instance: RESET_PC=0xFFFFFFFC, second fetch must be at 0x0.
    initial begin
        logic [31:0] got [2];
        w_gnt    = 1'b0;
        w_rvalid = 1'b0;
        w_rdata  = 32'h0;
        @(negedge rst);
        for (int k = 0; k < 2; k++) begin
            int n = 0;
            while (!w_req && n < 20) begin
                step();
                n++;
            end
            got[k] = w_addr;
            w_gnt = 1'b1;
            step();
            w_gnt    = 1'b0;
            w_rvalid = 1'b1;
            w_rdata  = 32'h0000_0013;
            step();
            w_rvalid = 1'b0;
        end
        chk("wrap_first", got[0], 32'hFFFF_FFFC);
        chk("wrap_second", got[1], 32'h0000_0000);
        w_done = 1'b1;
    end

    initial begin
        int n;
        rst             = 1'b1;
        imem_gnt        = 1'b0;
        imem_rvalid     = 1'b0;
        imem_rdata      = 32'h0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        instr_ready     = 1'b1;
        step();
        step();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_mis", {31'd0, misalign_err}, 32'd0);
        imem_rvalid = 1'b1;
        rst = 1'b0;
        step();
        imem_rvalid = 1'b0;
        chk("first_req", {31'd0, imem_req}, 32'd1);

        fetch(32'h0, 32'h0050_0093, 0, 1, 1'b1);
        chk("t1_valid", {31'd0, instr_valid}, 32'd1);
        chk("t1_opcode", {25'd0, opcode}, 32'h13);
        chk("t1_funct3", {29'd0, funct3}, 32'h0);
        chk("t1_pc", instr_pc, 32'h0);
        step();

        instr_ready = 1'b0;
        fetch(32'h4, 32'h00A0_0113, 3, 2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_instr", instr, 32'h00A0_0113);
            chk("hold_pc", instr_pc, 32'h4);
            chk("hold_noreq", {31'd0, imem_req}, 32'd0);
        end
        instr_ready = 1'b1;
        step();

        wait_req(32'h8);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        redirect(32'h100);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0008;
        step();
        imem_rvalid = 1'b0;
        fetch(32'h100, 32'h4020_81B3, 0, 1, 1'b1);
        chk("t4_opcode", {25'd0, opcode}, 32'h33);
        chk("t4_funct7", {25'd0, funct7}, 32'h20);
        chk("t4_pc", instr_pc, 32'h100);
        step();

        wait_req(32'h104);
        imem_gnt = 1'b1;
        step();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0104;
        redirect(32'h140);
        imem_rvalid = 1'b0;
        chk("rv_redir_valid", {31'd0, instr_valid}, 32'd0);

        instr_ready = 1'b0;
        fetch(32'h140, 32'h0030_0193, 0, 1, 1'b0);
        chk("t5_held", {31'd0, instr_valid}, 32'd1);
        chk("t5_pc", instr_pc, 32'h140);
        instr_ready = 1'b1;
        redirect(32'h180);
        chk("rdy_redir_valid", {31'd0, instr_valid}, 32'd0);
        fetch(32'h180, 32'h0040_0213, 0, 1, 1'b1);
        step();

        wait_req(32'h184);
        imem_gnt = 1'b1;
        redirect(32'h102);
        imem_gnt = 1'b0;
        chk("mis_set", {31'd0, misalign_err}, 32'd1);
        chk("mis_valid", {31'd0, instr_valid}, 32'd0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req) n++;
            step();
        end
        chk("mis_noreq", n, 0);
        redirect(32'h200);
        chk("mis_clear", {31'd0, misalign_err}, 32'd0);
        fetch(32'h200, 32'h0050_0293, 0, 1, 1'b1);
        step();

        n = 0;
        while ((sb.size() != 0 || !w_done) && n < 200) begin
            step();
            n++;
        end
        chk("sb_empty", sb.size(), 0);
        chk("wrap_done", {31'd0, w_done}, 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
